// File: rtl/keypad_pkg.sv
// Shared constants, state encoding and named keycodes for the 4x5 piano key matrix scanner.
package keypad_pkg;

    localparam int unsigned ROWS      = 4;
    localparam int unsigned COLS      = 5;
    localparam int unsigned KEYCODE_W = 5;
    localparam int unsigned ROW_IDX_W = 2;
    localparam int unsigned COL_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONFIRM = 2'd1,
        HELD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [KEYCODE_W-1:0] KEY_C      = 5'd4;
    localparam logic [KEYCODE_W-1:0] KEY_OCT_UP = 5'd15;
    localparam logic [KEYCODE_W-1:0] KEY_OCT_DN = 5'd19;

endpackage

// File: rtl/keypad_col_scan.sv
// Column ring with per-column dwell divider and 2-FF row synchronizer; strobes the row sample
// on the last dwell cycle of each column and flags the column-4 sample as frame_tick.
module keypad_col_scan
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic [ROWS-1:0]      row_sync,
    output logic                 sample,
    output logic [COL_IDX_W-1:0] col_idx,
    output logic                 frame_tick
);

    localparam int unsigned            DW         = $clog2(CLK_DIV);
    localparam logic [DW-1:0]          DWELL_LAST = DW'(CLK_DIV - 1);
    localparam logic [COL_IDX_W-1:0]   COL_LAST   = COL_IDX_W'(COLS - 1);
    localparam logic [COLS-1:0]        COL_ONE    = COLS'(1);

    logic [DW-1:0]   dwell;
    logic [ROWS-1:0] row_meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            dwell    <= '0;
            col_idx  <= '0;
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (sample) begin
                dwell   <= '0;
                col_idx <= (col_idx == COL_LAST) ? '0 : col_idx + 1'b1;
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    assign sample     = (dwell == DWELL_LAST);
    assign frame_tick = sample && (col_idx == COL_LAST);
    assign col        = ~(COL_ONE << col_idx);

endmodule

// File: rtl/keypad_scanner.sv
// Debounced single-key scanner for the piano key matrix; presents keycode plus level ready.
// Optional auto-repeat pulses on ready are enabled with the KEYPAD_REPEAT_EN macro.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_DIV         = 50000,
    parameter int unsigned DEBOUNCE_FRAMES = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = 100,
    parameter int unsigned REPEAT_PERIOD   = 25
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic [KEYCODE_W-1:0] keycode,
    output logic                 ready,
    output logic                 frame_tick
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [ROWS-1:0]      row_sync;
    logic                 sample;
    logic [COL_IDX_W-1:0] col_idx;

    state_t               state;
    logic [KEYCODE_W-1:0] cand;
    logic [KEYCODE_W-1:0] frame_key;
    logic                 frame_valid;
    logic                 frame_hit;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_inc;

    logic [ROWS-1:0]      pressed;
    logic                 col_any;
    logic [ROW_IDX_W-1:0] row_lo;
    logic                 eff_valid;
    logic                 eff_hit;
    logic [KEYCODE_W-1:0] eff_key;

    keypad_col_scan #(.CLK_DIV(CLK_DIV)) u_col_scan (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .row_sync   (row_sync),
        .sample     (sample),
        .col_idx    (col_idx),
        .frame_tick (frame_tick)
    );

    // Frame accumulators merged with the current column's sample, so the FSM sees the whole frame.
    always_comb begin
        pressed = ~row_sync;
        col_any = 1'b0;
        row_lo  = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (pressed[r] && !col_any) begin
                col_any = 1'b1;
                row_lo  = ROW_IDX_W'(r);
            end
        end
        eff_valid = frame_valid | col_any;
        eff_key   = frame_valid ? frame_key : {col_idx, row_lo};
        eff_hit   = frame_hit |
                    ((cand[KEYCODE_W-1:ROW_IDX_W] == col_idx) && pressed[cand[ROW_IDX_W-1:0]]);
        cnt_inc   = (cnt == CNT_DONE) ? cnt : cnt + CNT_ONE;
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_inc;
    logic [REP_W-1:0] rep_target;
    logic             rep_first;

    always_comb begin
        rep_inc    = rep_cnt + REP_W'(1);
        rep_target = rep_first ? REP_W'(REPEAT_DELAY) : REP_W'(REPEAT_PERIOD);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ready       <= 1'b0;
            keycode     <= '0;
            cand        <= '0;
            cnt         <= '0;
            frame_valid <= 1'b0;
            frame_key   <= '0;
            frame_hit   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else if (frame_tick) begin
            frame_valid <= 1'b0;
            frame_key   <= '0;
            frame_hit   <= 1'b0;
            case (state)
                IDLE: begin
                    if (eff_valid) begin
                        cand <= eff_key;
                        cnt  <= CNT_ONE;
                        if (CNT_DONE == CNT_ONE) begin
                            keycode <= eff_key;
                            ready   <= 1'b1;
                            state   <= HELD;
                        end else begin
                            state <= CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (eff_hit) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            keycode <= cand;
                            ready   <= 1'b1;
                            state   <= HELD;
                        end
                    end else if (eff_valid) begin
                        cand <= eff_key;
                        cnt  <= CNT_ONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                HELD: begin
                    if (!eff_hit) begin
                        cnt   <= CNT_ONE;
                        ready <= 1'b1;
                        state <= RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else begin
                        ready <= (rep_inc != rep_target);
                    end
`endif
                end
                RELEASE: begin
                    if (eff_hit) begin
                        state <= HELD;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            ready <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef KEYPAD_REPEAT_EN
            // Clearing whenever the hold does not continue covers every entry into HELD or RELEASE.
            if (state == HELD && eff_hit) begin
                if (rep_inc == rep_target) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_inc;
                end
            end else begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end
`endif
        end else if (sample) begin
            frame_valid <= eff_valid;
            frame_key   <= eff_key;
            frame_hit   <= eff_hit;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Randomized and directed bench for keypad_scanner (CLK_DIV=4, DEBOUNCE_FRAMES=3, 20-cycle frames).
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int DF      = 3;
    localparam int FRAME   = 5 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [4:0] col;
    logic [4:0] keycode;
    logic       ready;
    logic       frame_tick;

    logic [19:0] pressed = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state: frame observation set plus the debounce rules
    int          cyc;
    logic [19:0] seen;
    int          m_state;
    int          m_cand;
    int          m_cnt;
    logic        m_ready;
    logic [4:0]  m_keycode;

    always #5 clk = ~clk;

    keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_FRAMES(DF)) dut (
        .clk        (clk),
        .rst        (rst),
        .row        (row),
        .col        (col),
        .keycode    (keycode),
        .ready      (ready),
        .frame_tick (frame_tick)
    );

    // Passive matrix: a row reads low when a pressed key sits on a driven column
    always_comb begin
        row = '1;
        for (int c = 0; c < 5; c++)
            if (!col[c])
                for (int r = 0; r < 4; r++)
                    if (pressed[c*4 + r]) row[r] = 1'b0;
    end

    task automatic model_reset();
        cyc       = 0;
        seen      = '0;
        m_state   = 0;
        m_cand    = 0;
        m_cnt     = 0;
        m_ready   = 1'b0;
        m_keycode = '0;
    endtask

    task automatic model_frame_end();
        int lowest;
        bit hit;
        lowest = -1;
        for (int k = 0; k < 20; k++) if (seen[k] && lowest < 0) lowest = k;
        hit = seen[m_cand];
        case (m_state)
            0: if (lowest >= 0) begin
                m_cand = lowest;
                m_cnt  = 1;
                if (DF == 1) begin
                    m_keycode = 5'(lowest); m_ready = 1'b1; m_state = 2;
                end else m_state = 1;
            end
            1: if (hit) begin
                m_cnt = m_cnt + 1;
                if (m_cnt >= DF) begin m_keycode = 5'(m_cand); m_ready = 1'b1; m_state = 2; end
            end else if (lowest >= 0) begin
                m_cand = lowest; m_cnt = 1;
            end else m_state = 0;
            2: if (!hit) begin m_cnt = 1; m_state = 3; end
            default: if (hit) m_state = 2;
            else begin
                m_cnt = m_cnt + 1;
                if (m_cnt >= DF) begin m_ready = 1'b0; m_state = 0; end
            end
        endcase
        seen = '0;
    endtask

    // Advance one clock; a column is observed two edges before its sample because of the synchronizer
    task automatic tick();
        int e;
        e = cyc;
        if ((e % CLK_DIV) == CLK_DIV - 3) begin
            int c;
            c = (e % FRAME) / CLK_DIV;
            for (int r = 0; r < 4; r++) seen[c*4 + r] = pressed[c*4 + r];
        end
        if ((e % FRAME) == FRAME - 1) model_frame_end();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
    endtask

    task automatic test_reset();
        logic [4:0] exp_col;
        logic       exp_tick;
        pressed = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || keycode !== 5'd0 || col !== 5'b11110 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b keycode=%0d col=%b tick=%b, expected 0 0 11110 0",
                     ready, keycode, col, frame_tick);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            exp_col  = ~(5'b00001 << ((cyc % FRAME) / CLK_DIV));
            exp_tick = ((cyc % FRAME) == FRAME - 1);
            n_checks++;
            if (col !== exp_col || frame_tick !== exp_tick || ready !== 1'b0 || keycode !== 5'd0) begin
                n_fail++;
                $display("FAIL idle_scan cyc=%0d: col=%b tick=%b ready=%b keycode=%0d, expected %b %b 0 0",
                         cyc, col, frame_tick, ready, keycode, exp_col, exp_tick);
            end
        end
    endtask

    task automatic test_single_key();
        pressed = '0;
        pressed[KEY_C] = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (ready !== m_ready || keycode !== m_keycode) begin
                n_fail++;
                $display("FAIL single_press cyc=%0d: ready=%b keycode=%0d, expected %b %0d",
                         cyc, ready, keycode, m_ready, m_keycode);
            end
        end
        n_checks++;
        if (ready !== 1'b1 || keycode !== KEY_C) begin
            n_fail++;
            $display("FAIL single_confirm: ready=%b keycode=%0d, expected 1 4", ready, keycode);
        end
        pressed = '0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (ready !== m_ready || keycode !== m_keycode) begin
                n_fail++;
                $display("FAIL single_release cyc=%0d: ready=%b keycode=%0d, expected %b %0d",
                         cyc, ready, keycode, m_ready, m_keycode);
            end
        end
        n_checks++;
        if (ready !== 1'b0 || keycode !== KEY_C) begin
            n_fail++;
            $display("FAIL single_released: ready=%b keycode=%0d, expected 0 4", ready, keycode);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5 * FRAME; i++) begin
            pressed = '0;
            pressed[13] = ((i / 10) % 2 == 0);
            tick();
            n_checks++;
            if (ready !== 1'b0 || ready !== m_ready) begin
                n_fail++;
                $display("FAIL bounce_reject cyc=%0d: ready=%b, expected 0", cyc, ready);
            end
        end
        pressed = '0;
        pressed[13] = 1'b1;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (ready !== m_ready || keycode !== m_keycode) begin
                n_fail++;
                $display("FAIL bounce_settle cyc=%0d: ready=%b keycode=%0d, expected %b %0d",
                         cyc, ready, keycode, m_ready, m_keycode);
            end
        end
        n_checks++;
        if (ready !== 1'b1 || keycode !== 5'd13) begin
            n_fail++;
            $display("FAIL bounce_confirm: ready=%b keycode=%0d, expected 1 13", ready, keycode);
        end
        pressed = '0;
        repeat (3 * FRAME) tick();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_release: ready=%b, expected 0", ready);
        end
    endtask

    task automatic test_two_keys();
        pressed = '0;
        pressed[6]  = 1'b1;
        pressed[12] = 1'b1;
        for (int phase = 0; phase < 4; phase++) begin
            if (phase == 1) pressed[6] = 1'b0;
            if (phase == 3) pressed = '0;
            for (int i = 0; i < 3 * FRAME; i++) begin
                tick();
                n_checks++;
                if (ready !== m_ready || keycode !== m_keycode) begin
                    n_fail++;
                    $display("FAIL two_keys phase=%0d cyc=%0d: ready=%b keycode=%0d, expected %b %0d",
                             phase, cyc, ready, keycode, m_ready, m_keycode);
                end
            end
            n_checks++;
            if ((phase == 0 && (ready !== 1'b1 || keycode !== 5'd6)) ||
                (phase == 1 && ready !== 1'b0) ||
                (phase == 2 && (ready !== 1'b1 || keycode !== 5'd12))) begin
                n_fail++;
                $display("FAIL two_keys_end phase=%0d: ready=%b keycode=%0d", phase, ready, keycode);
            end
        end
    endtask

    task automatic test_dropout();
        pressed = '0;
        pressed[KEY_OCT_UP] = 1'b1;
        repeat (3 * FRAME) tick();
        n_checks++;
        if (ready !== 1'b1 || keycode !== KEY_OCT_UP) begin
            n_fail++;
            $display("FAIL dropout_confirm: ready=%b keycode=%0d, expected 1 15", ready, keycode);
        end
        for (int i = 0; i < 3 * FRAME; i++) begin
            pressed[KEY_OCT_UP] = !(i < FRAME);
            tick();
            n_checks++;
            if (ready !== 1'b1 || ready !== m_ready || keycode !== KEY_OCT_UP) begin
                n_fail++;
                $display("FAIL dropout_hold cyc=%0d: ready=%b keycode=%0d, expected 1 15",
                         cyc, ready, keycode);
            end
        end
        pressed = '0;
        repeat (3 * FRAME) tick();
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL dropout_release: ready=%b, expected 0", ready);
        end
    endtask

    task automatic test_mid_reset();
        pressed = '0;
        pressed[KEY_OCT_DN] = 1'b1;
        repeat (3 * FRAME + 7) tick();
        n_checks++;
        if (ready !== 1'b1 || keycode !== KEY_OCT_DN) begin
            n_fail++;
            $display("FAIL midrst_held: ready=%b keycode=%0d, expected 1 19", ready, keycode);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0 || col !== 5'b11110) begin
            n_fail++;
            $display("FAIL midrst_clear: ready=%b col=%b, expected 0 11110", ready, col);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if (ready !== m_ready || keycode !== m_keycode) begin
                n_fail++;
                $display("FAIL midrst_reacquire cyc=%0d: ready=%b keycode=%0d, expected %b %0d",
                         cyc, ready, keycode, m_ready, m_keycode);
            end
        end
        n_checks++;
        if (ready !== 1'b1 || keycode !== KEY_OCT_DN) begin
            n_fail++;
            $display("FAIL midrst_confirm: ready=%b keycode=%0d, expected 1 19", ready, keycode);
        end
        pressed = '0;
        repeat (3 * FRAME) tick();
    endtask

    task automatic test_random();
        logic [19:0] base;
        logic [4:0]  exp_col;
        int          nkeys, len, g_at, g_len, g_key;
        for (int s = 0; s < 40; s++) begin
            base  = '0;
            nkeys = $urandom_range(0, 2);
            for (int k = 0; k < nkeys; k++) base[$urandom_range(0, 19)] = 1'b1;
            len   = $urandom_range(1, 4) * FRAME;
            g_at  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            g_len = $urandom_range(1, 6);
            g_key = $urandom_range(0, 19);
            for (int i = 0; i < len; i++) begin
                pressed = base;
                if (g_at >= 0 && i >= g_at && i < g_at + g_len) pressed[g_key] = ~base[g_key];
                tick();
                exp_col = ~(5'b00001 << ((cyc % FRAME) / CLK_DIV));
                n_checks++;
                if (ready !== m_ready || keycode !== m_keycode || col !== exp_col ||
                    frame_tick !== ((cyc % FRAME) == FRAME - 1)) begin
                    n_fail++;
                    $display("FAIL random seg=%0d cyc=%0d: ready=%b keycode=%0d col=%b, expected %b %0d %b",
                             s, cyc, ready, keycode, col, m_ready, m_keycode, exp_col);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_bounce();
        test_two_keys();
        test_dropout();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 4-row x 5-column piano key matrix, debounces it and presents one stable key to the note decoder as keycode plus level ready.
- Sits between the board's matrix pins and the piano_keypad note/octave decoder.
- Sequences the decoder handshake: ready is high only while a debounced key is held.
- Single-key policy: the first confirmed key owns the output until it is released.

Parameters:
- CLK_DIV, 50000, clk cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_FRAMES, 4, consecutive full scan frames needed to confirm a press or a release; minimum 1.
- REPEAT_DELAY, 100, frames held before the first auto-repeat (optional feature only).
- REPEAT_PERIOD, 25, frames between later auto-repeats (optional feature only).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- row  input  4  matrix rows, active-low, pulled up externally, asynchronous to clk.
- col  output  5  column drive, active-low one-hot.
- keycode  output  5  debounced key = col_index*4 + row_index, range 0..19.
- ready  output  1  high while the debounced key in keycode is held.
- frame_tick  output  1  one-cycle pulse on the last cycle of each 5-column frame.

Behaviour:
- Reset values:
  - col=5'b11110 (column 0 driven), dwell counter 0, column index 0.
  - keycode=0, ready=0, frame_tick=0, state IDLE.
  - Row synchronizer cleared to all-ones (no key pressed).
- Scan:
  - row passes through a 2-FF synchronizer.
  - Rows are sampled on the last cycle of each dwell, then col rotates to the next column (4 wraps to 0).
  - One frame is 5*CLK_DIV cycles. frame_tick is high on the cycle the column-4 sample is taken.
- Per-frame accumulation, cleared at frame start:
  - frame_valid and frame_key record the lowest pressed keycode in the frame.
  - frame_hit is set if key cand was seen pressed.
- FSM, evaluated only on frame_tick, after including that cycle's sample:
  - IDLE: if frame_valid, set cand=frame_key, cnt=1, go to CONFIRM (or straight to HELD when DEBOUNCE_FRAMES=1).
  - CONFIRM:
    - frame_hit: cnt++. When cnt reaches DEBOUNCE_FRAMES, set keycode=cand, ready=1, go to HELD.
    - Not frame_hit but frame_valid: restart with cand=frame_key, cnt=1.
    - Otherwise: go to IDLE.
  - HELD: ready=1. If not frame_hit, set cnt=1 and go to RELEASE. Other keys are ignored.
  - RELEASE: ready stays 1.
    - frame_hit: go back to HELD.
    - Otherwise cnt++. When cnt reaches DEBOUNCE_FRAMES, set ready=0 and go to IDLE.
- Output timing:
  - ready and keycode update on the clk edge after frame_tick (1-cycle latency from the frame end).
  - keycode keeps its last value after release.
- Boundary conditions:
  - Simultaneous keys: the lowest keycode wins in IDLE/CONFIRM. Once HELD, a second key never changes keycode.
  - Bounce shorter than a frame is not detected. Any missed frame in CONFIRM restarts or aborts the confirmation.
  - rst mid-frame: scan restarts at column 0 and ready drops on the next edge.
  - Counters saturate; they never wrap within a state.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- When defined, while in HELD:
  - After REPEAT_DELAY frames, ready is driven low for exactly one frame, then high again.
  - This repeats every REPEAT_PERIOD frames.
  - keycode is unchanged throughout.
  - Purpose: each repeat gives the decoder a fresh ready rising edge (octave-hold stepping).
  - The repeat counter is cleared on entry to HELD or RELEASE.
- When undefined: ready stays high for the whole hold, and the repeat counter and logic are absent.

Decomposition:
- Package keypad_pkg holds:
  - ROWS=4, COLS=5, KEYCODE_W=5.
  - State encoding IDLE/CONFIRM/HELD/RELEASE.
  - Named keycodes KEY_C=4, KEY_OCT_UP=15, KEY_OCT_DN=19.
- One sub-module, keypad_col_scan, contains:
  - The dwell divider and the column ring.
  - The row synchronizer.
  - Outputs for sample strobe, column index and frame_tick.
- The FSM and accumulation stay in keypad_scanner.

Test Plan (CLK_DIV=4, DEBOUNCE_FRAMES=3, frame=20 cycles):
- Reset, no keys:
  - col cycles 11110, 11101, 11011, 10111, 01111, each held 4 cycles.
  - frame_tick every 20 cycles; ready=0 and keycode=0 throughout.
- Press key 4 (col1,row0) stable from a frame start: ready=1 and keycode=4 one cycle after the 3rd frame_tick. Release it: ready=0 one cycle after the 3rd empty frame.
- Key 13 toggles every 10 cycles (bounce) for 5 frames: ready stays 0. Then key 13 is held stable: ready rises after 3 clean frames.
- Keys 6 and 12 pressed together: keycode=6. Release 6 while 12 is held: ready drops after 3 frames, then re-rises with keycode=12 after 3 more frames.
- Key 15 held, then a single-frame dropout: state goes to RELEASE and back to HELD, with ready staying 1 throughout.
- Assert rst mid-frame with key 19 HELD: next cycle ready=0, col=11110. Key 19 still held: ready=1 after 3 frames.
- With KEYPAD_REPEAT_EN (REPEAT_DELAY=5, REPEAT_PERIOD=2): holding key 15 gives ready low for 20 cycles after 5 held frames, then low again every 2 frames.
